thumb_fetch_unit: RTL and testbench
===================================

Name: thumb_fetch_unit

Overview:
- Instruction fetch front end that drives the dual-bank Program_Rom read interface: word-row address, odd-halfword carry, and bank-mux selects.
- Captures the returned IR_0/IR_1 halfwords into a 2-slot issue buffer feeding the dual-issue decoder.
- Handles sequential fetch at even or odd halfword alignment, partial consumption, branch redirect, 32-bit Thumb prefix pairing and end-of-program.

Parameters:
- ADDR_W, 14, ROM row address width; halfword PC width is ADDR_W+1.
- PROG_LEN, 5, number of valid program halfwords; addresses >= PROG_LEN are never issued.
- RESET_PC, 0, halfword address fetched after reset.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rom_addr  out  ADDR_W  to ROM Rom_addr_in; equals fetch_pc[ADDR_W:1]
- rom_pc_1  out  1  to ROM pc_1; equals fetch_pc[0]
- rom_sel_mem_1  out  1  to ROM sel_mem_1; equals ~fetch_pc[0]
- rom_sel_mem_0  out  2  to ROM sel_mem_0; 0 when fetch_pc even, 2 when odd; value 1 never driven
- rom_ir_0  in  16  ROM IR_0: halfword at fetch_pc
- rom_ir_1  in  16  ROM IR_1: halfword at fetch_pc+1
- dec_valid_0  out  1  slot0 holds an issuable instruction
- dec_valid_1  out  1  slot1 valid
- dec_instr_0  out  16  slot0 halfword
- dec_instr_1  out  16  slot1 halfword
- dec_pc_0  out  ADDR_W+1  halfword address of slot0 (slot1 = dec_pc_0+1)
- dec_wide_0  out  1  slot0/slot1 form one 32-bit instruction
- dec_take  in  2  slots consumed this cycle (0, 1 or 2)
- br_valid  in  1  redirect request
- br_target  in  ADDR_W+1  redirect halfword address

Behaviour:
- fetch_pc register holds the next unfetched halfword address. ROM outputs are combinational from the rom_* outputs; ROM outputs are sampled the same cycle.
- Slot contents (instr, valid, pc) are registered. All dec_* outputs come directly from registers.
- Reset values: fetch_pc=RESET_PC; state=FILL; all valid=0; instr=0; dec_pc_0=0; dec_wide_0=0.
- FSM states: FILL, RUN, END.
  - FILL (buffer empty): load slot0 from rom_ir_0 and slot1 from rom_ir_1. fetch_pc += number of slots loaded. Go to RUN.
  - RUN: apply the consumption/refill rules below.
  - END: entered when fetch_pc >= PROG_LEN. No further loads; remaining slots drain via dec_take. Leave only on br_valid or rst.
- Consumption/refill in RUN. Effective take = min(dec_take, consumable count); larger values are clamped, never underflow.
  - take 0: hold everything.
  - take 2, or take 1 when only slot0 valid: refill both slots as in FILL.
  - take 1 with both valid: slot0 <= slot1; slot1 <= rom_ir_0; fetch_pc += 1.
- Bound check: a slot loaded from address a is valid only if a < PROG_LEN. fetch_pc advances only by the count of valid loads. When it reaches PROG_LEN, go to END.
- Wide pairing:
  - Prefix = instr[15:11] in {11101, 11110, 11111}.
  - When slot0 is a prefix: dec_wide_0=1 and dec_valid_0=1 only if slot1 is valid; otherwise dec_valid_0=0 until slot1 fills.
  - The decoder must take 2 for a wide instruction. A take of 1 on a wide slot0 is treated as 0.
- Redirect: br_valid flushes both slots (valid=0), sets fetch_pc=br_target and state=FILL, regardless of dec_take. New slots are valid 2 cycles after br_valid (FILL cycle, then loaded). If br_target >= PROG_LEN, go directly to END with an empty buffer.
- Priority: rst > br_valid > dec_take.
- Reset mid-operation: all state returns to reset values on the next edge; in-flight slots are discarded.
- fetch_pc arithmetic is ADDR_W+1 bits, modulo 2^(ADDR_W+1). Wrap is never reached when PROG_LEN <= 2^(ADDR_W+1)-2.

Test Plan:
ROM image for scenarios 1–3, 5 and 6: hw0=0x210A, hw1=0x220C, hw2=0x230E, hw3=0xB40E, hw4=0xBC70; PROG_LEN=5.
1. Reset, then take=2 every cycle -> rom_addr=0, rom_pc_1=0, sel_mem_0=0, sel_mem_1=1. Slots over successive cycles: (0x210A@0, 0x220C); (0x230E@2, 0xB40E); (0xBC70@4, valid_1=0); then END with both valid=0.
2. take=1 every cycle -> dec_instr_0 sequence 0x210A, 0x220C, 0x230E, 0xB40E, 0xBC70. At fetch_pc=3: rom_addr=1, rom_pc_1=1, sel_mem_0=2, sel_mem_1=0, and slot1 loads 0xB40E.
3. br_valid with br_target=3 while take=2 -> next cycle both valid=0. The following cycle: slots 0xB40E@3 and 0xBC70; rom_addr=1, rom_pc_1=1, sel_mem_0=2.
4. ROM hw1=0xF000, hw2=0xF800; take=1 -> when slot0=0xF000 with slot1 valid, dec_wide_0=1; take=1 holds state; take=2 advances dec_pc_0 to 3.
5. take=0 for 4 cycles after fill -> outputs and fetch_pc frozen. br_target=7 -> END, valid=0 held indefinitely.
6. rst asserted together with br_valid mid-run -> next cycle matches reset values; fetch_pc=0 and slots reload 0x210A/0x220C.

Source files
------------

// File: rtl/thumb_fetch_unit.sv
// thumb_fetch_unit: dual-bank ROM fetch front end feeding a 2-slot issue buffer for a dual-issue Thumb decoder
module thumb_fetch_unit #(
  parameter int ADDR_W   = 14,
  parameter int PROG_LEN = 5,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_pc_1,
  output logic              rom_sel_mem_1,
  output logic [1:0]        rom_sel_mem_0,
  input  logic [15:0]       rom_ir_0,
  input  logic [15:0]       rom_ir_1,
  output logic              dec_valid_0,
  output logic              dec_valid_1,
  output logic [15:0]       dec_instr_0,
  output logic [15:0]       dec_instr_1,
  output logic [ADDR_W:0]   dec_pc_0,
  output logic              dec_wide_0,
  input  logic [1:0]        dec_take,
  input  logic              br_valid,
  input  logic [ADDR_W:0]   br_target
);
  localparam int PW = ADDR_W + 1;
  localparam logic [PW-1:0] LEN = PW'(PROG_LEN);
  localparam logic [PW-1:0] ONE = PW'(1);
  typedef enum logic [1:0] {S_FILL, S_RUN, S_END} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] fpc_q, fpc_d, pc0_q, pc0_d, fpc1;
  logic [15:0] i0_q, i0_d, i1_q, i1_d;
  logic v0_q, v0_d, v1_q, v1_d, dv0_q, dv0_d, wide_q, wide_d;
  logic [1:0] cnt, tk_raw, tk;
  logic ok0, ok1, run, refill, shift;
  function automatic logic is_pfx(input logic [15:0] h);
    return h[15:13] == 3'b111 && h[12:11] != 2'b00;
  endfunction
  assign rom_addr      = fpc_q[ADDR_W:1];
  assign rom_pc_1      = fpc_q[0];
  assign rom_sel_mem_1 = ~fpc_q[0];
  assign rom_sel_mem_0 = {fpc_q[0], 1'b0};
  assign dec_valid_0   = dv0_q;
  assign dec_valid_1   = v1_q;
  assign dec_instr_0   = i0_q;
  assign dec_instr_1   = i1_q;
  assign dec_pc_0      = pc0_q;
  assign dec_wide_0    = wide_q;
  // A prefix waiting on its suffix is not issuable, so it counts as nothing consumable
  assign cnt    = dv0_q ? (v1_q ? 2'd2 : 2'd1) : 2'd0;
  assign tk_raw = dec_take > cnt ? cnt : dec_take;
  assign tk     = (wide_q && tk_raw == 2'd1) ? 2'd0 : tk_raw;
  assign fpc1   = fpc_q + ONE;
  assign ok0    = fpc_q < LEN;
  assign ok1    = ok0 && fpc1 < LEN;
  assign run    = state_q == S_RUN;
  assign refill = state_q == S_FILL || (run && tk != 2'd0 && tk == cnt);
  assign shift  = tk == 2'd1 && cnt == 2'd2;
  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    pc0_d   = pc0_q;
    i0_d    = i0_q;
    i1_d    = i1_q;
    v0_d    = v0_q;
    v1_d    = v1_q;
    if (refill) begin
      i0_d  = rom_ir_0;
      i1_d  = rom_ir_1;
      v0_d  = ok0;
      v1_d  = ok1;
      pc0_d = fpc_q;
      fpc_d = fpc_q + PW'(ok0) + PW'(ok1);
    end else if (shift) begin
      i0_d  = i1_q;
      v0_d  = 1'b1;
      pc0_d = pc0_q + ONE;
      i1_d  = rom_ir_0;
      v1_d  = run && ok0;
      fpc_d = fpc_q + PW'(run && ok0);
    end else if (tk != 2'd0) begin
      v0_d = 1'b0;
      v1_d = 1'b0;
    end
    if (state_q != S_END) state_d = fpc_d >= LEN ? S_END : S_RUN;
    if (br_valid) begin
      v0_d    = 1'b0;
      v1_d    = 1'b0;
      fpc_d   = br_target;
      state_d = br_target >= LEN ? S_END : S_FILL;
    end
    dv0_d  = v0_d && (!is_pfx(i0_d) || v1_d);
    wide_d = v0_d && is_pfx(i0_d) && v1_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FILL;
      fpc_q   <= PW'(RESET_PC);
      pc0_q   <= '0;
      i0_q    <= '0;
      i1_q    <= '0;
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
      dv0_q   <= 1'b0;
      wide_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      pc0_q   <= pc0_d;
      i0_q    <= i0_d;
      i1_q    <= i1_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      dv0_q   <= dv0_d;
      wide_q  <= wide_d;
    end
  end
endmodule

// File: tb/tb_thumb_fetch_unit.sv
// tb_thumb_fetch_unit: directed + random stimulus against a queue-based model of the fetch buffer
module tb_thumb_fetch_unit;
  localparam int PL = 5;
  logic clk = 0, rst = 1, br_valid = 0;
  logic [13:0] rom_addr;
  logic rom_pc_1, rom_sel_mem_1, dec_valid_0, dec_valid_1, dec_wide_0;
  logic [1:0] rom_sel_mem_0, dec_take = 0;
  logic [15:0] rom_ir_0, rom_ir_1, dec_instr_0, dec_instr_1;
  logic [14:0] dec_pc_0, br_target = 0, ra, ra1;
  logic [15:0] rom [0:15];
  int vec = 0, err = 0;
  int q[$];
  int m_fpc = 0, m_st = 0, cnt, tk;
  always #5 clk = ~clk;
  thumb_fetch_unit dut (
    .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_pc_1(rom_pc_1),
    .rom_sel_mem_1(rom_sel_mem_1), .rom_sel_mem_0(rom_sel_mem_0),
    .rom_ir_0(rom_ir_0), .rom_ir_1(rom_ir_1),
    .dec_valid_0(dec_valid_0), .dec_valid_1(dec_valid_1),
    .dec_instr_0(dec_instr_0), .dec_instr_1(dec_instr_1),
    .dec_pc_0(dec_pc_0), .dec_wide_0(dec_wide_0),
    .dec_take(dec_take), .br_valid(br_valid), .br_target(br_target)
  );
  assign ra  = {rom_addr, rom_pc_1};
  assign ra1 = ra + 15'd1;
  assign rom_ir_0 = ra < 15'd16 ? rom[ra[3:0]] : 16'hDEAD;
  assign rom_ir_1 = ra1 < 15'd16 ? rom[ra1[3:0]] : 16'hDEAD;
  function automatic logic [15:0] romv(input int a);
    return a < 16 ? rom[a] : 16'hDEAD;
  endfunction
  function automatic bit pfx(input logic [15:0] h);
    return h[15:11] inside {5'b11101, 5'b11110, 5'b11111};
  endfunction
  function automatic bit m_v0();
    return q.size() >= 1 && (!pfx(romv(q[0])) || q.size() >= 2);
  endfunction
  function automatic bit m_wide();
    return q.size() == 2 && pfx(romv(q[0]));
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    if (rst) begin
      q = {}; m_fpc = 0; m_st = 0;
    end else if (br_valid) begin
      q = {}; m_fpc = int'(br_target); m_st = br_target >= PL ? 2 : 0;
    end else begin
      cnt = m_v0() ? q.size() : 0;
      tk = int'(dec_take) < cnt ? int'(dec_take) : cnt;
      if (tk == 1 && m_wide()) tk = 0;
      for (int i = 0; i < tk; i++) void'(q.pop_front());
      if (m_st == 0 || (m_st == 1 && tk > 0))
        while (q.size() < 2 && m_fpc < PL) begin q.push_back(m_fpc); m_fpc++; end
      if (m_st != 2) m_st = m_fpc >= PL ? 2 : 1;
    end
  end
  always @(negedge clk) begin
    chk("rom_addr", rom_addr, (m_fpc >> 1) & 32'h3FFF);
    chk("rom_pc_1", rom_pc_1, m_fpc & 1);
    chk("sel_mem_1", rom_sel_mem_1, (m_fpc & 1) ^ 1);
    chk("sel_mem_0", rom_sel_mem_0, (m_fpc & 1) ? 2 : 0);
    chk("valid_0", dec_valid_0, m_v0());
    chk("valid_1", dec_valid_1, q.size() >= 2);
    chk("wide_0", dec_wide_0, m_wide());
    if (q.size() >= 1 && m_v0()) begin
      chk("instr_0", dec_instr_0, romv(q[0]));
      chk("pc_0", dec_pc_0, q[0]);
    end
    if (q.size() >= 2) chk("instr_1", dec_instr_1, romv(q[1]));
  end
  task automatic step(input int t, input bit b = 0, input int tg = 0, input bit r = 0);
    #1;
    dec_take = 2'(t); br_valid = b; br_target = 15'(tg); rst = r;
    @(negedge clk);
  endtask
  task automatic base_rom();
    #1;
    for (int i = 0; i < 16; i++) rom[i] = 16'h1000 + 16'(i);
    rom[0] = 16'h210A; rom[1] = 16'h220C; rom[2] = 16'h230E; rom[3] = 16'hB40E; rom[4] = 16'hBC70;
  endtask
  initial begin
    base_rom();
    @(negedge clk);
    chk("rst_v0", dec_valid_0, 0); chk("rst_v1", dec_valid_1, 0);
    chk("rst_pc", dec_pc_0, 0); chk("rst_addr", rom_addr, 0);
    chk("rst_sel1", rom_sel_mem_1, 1); chk("rst_sel0", rom_sel_mem_0, 0);
    // take 2 every cycle
    step(2); chk("s1_i0", dec_instr_0, 16'h210A); chk("s1_i1", dec_instr_1, 16'h220C);
    step(2); chk("s1_i0b", dec_instr_0, 16'h230E); chk("s1_pcb", dec_pc_0, 2); chk("s1_i1b", dec_instr_1, 16'hB40E);
    step(2); chk("s1_i0c", dec_instr_0, 16'hBC70); chk("s1_pcc", dec_pc_0, 4); chk("s1_v1c", dec_valid_1, 0);
    step(2); chk("s1_end", dec_valid_0, 0);
    step(2);
    // take 1 every cycle
    step(0, 0, 0, 1);
    step(1); step(1); chk("s2_i0", dec_instr_0, 16'h220C);
    chk("s2_addr", rom_addr, 1); chk("s2_pc1", rom_pc_1, 1); chk("s2_sel0", rom_sel_mem_0, 2); chk("s2_sel1", rom_sel_mem_1, 0);
    step(1); chk("s2_i0b", dec_instr_0, 16'h230E); chk("s2_i1b", dec_instr_1, 16'hB40E);
    step(1); step(1); chk("s2_i0c", dec_instr_0, 16'hBC70);
    step(1); chk("s2_end", dec_valid_0, 0);
    // redirect to 3
    step(0, 0, 0, 1);
    step(2); step(2, 1, 3); chk("s3_v0", dec_valid_0, 0);
    chk("s3_addr", rom_addr, 1); chk("s3_pc1", rom_pc_1, 1); chk("s3_sel0", rom_sel_mem_0, 2);
    step(2); chk("s3_i0", dec_instr_0, 16'hB40E); chk("s3_pc", dec_pc_0, 3); chk("s3_i1", dec_instr_1, 16'hBC70);
    // wide pairing
    base_rom(); rom[1] = 16'hF000; rom[2] = 16'hF800;
    step(0, 0, 0, 1);
    step(1); step(1); chk("s4_wide", dec_wide_0, 1); chk("s4_pc", dec_pc_0, 1);
    step(1); chk("s4_hold", dec_pc_0, 1); chk("s4_wide2", dec_wide_0, 1);
    step(2); chk("s4_adv", dec_pc_0, 3);
    // freeze, then redirect past the end
    base_rom();
    step(0, 0, 0, 1);
    step(0); for (int i = 0; i < 4; i++) step(0);
    chk("s5_pc", dec_pc_0, 0); chk("s5_i0", dec_instr_0, 16'h210A); chk("s5_addr", rom_addr, 1);
    step(0, 1, 7); for (int i = 0; i < 3; i++) step(2);
    chk("s5_end", dec_valid_0, 0);
    // reset beats redirect
    step(0, 0, 0, 1);
    step(2); step(2); step(2, 1, 3, 1);
    chk("s6_v0", dec_valid_0, 0); chk("s6_addr", rom_addr, 0);
    step(2); chk("s6_i0", dec_instr_0, 16'h210A); chk("s6_pc", dec_pc_0, 0); chk("s6_i1", dec_instr_1, 16'h220C);
    for (int n = 0; n < 1500; n++) begin
      if ($urandom % 40 == 0) begin
        #1;
        for (int i = 0; i < 16; i++) begin
          rom[i] = 16'($urandom);
          if ($urandom % 3 == 0) rom[i][15:11] = 5'b11101 + 5'($urandom % 3);
        end
        step(0, 0, 0, 1);
      end else if ($urandom % 10 == 0) step($urandom % 4, 1, $urandom % 8);
      else step($urandom % 4);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
